// File: rtl/bus_stim_gen_if.sv
// Bus-activity stimulus interface: controls into the generator, generated bus and activity count out.
// Latency: pure wiring, no state.
// Backpressure: none; the consumer samples A while valid is high and cannot stall the generator.
//
// Signals:
//   en      advance enable, sampled on the rising clock
//   mode    00 ADDR, 01 DATA, 10 STRIDE, 11 HOLD
//   clr     synchronous clear of tog_cnt
//   A       generated bus value
//   valid   A holds a value produced on the last edge
//   jump    A was produced by an ADDR block jump
//   tog_cnt saturating cumulative Hamming toggle count of A
interface bus_stim_gen_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic             clr;
    logic [W-1:0]     A;
    logic             valid;
    logic             jump;
    logic [CNT_W-1:0] tog_cnt;

    // master: the generator, which owns the produced bus
    modport master (
        input  en, mode, clr,
        output A, valid, jump, tog_cnt
    );

    // slave: the controller / encoder side that steps the generator and watches the bus
    modport slave (
        output en, mode, clr,
        input  A, valid, jump, tog_cnt
    );
endinterface

// File: rtl/bus_stim_gen.sv
// Stimulus generator: address-like, strided, pseudo-random or held W-bit bus plus its toggle count.
// Latency: one edge; an enabled edge updates A, jump, valid and tog_cnt together.
// Backpressure: none; en=0 freezes A, the LFSR and tog_cnt and drops valid/jump.
//
// Ports:
//   ck   clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  bus_stim_gen_if.master (en, mode, clr in; A, valid, jump, tog_cnt out)
module bus_stim_gen #(
    parameter int          W      = 8,
    parameter int          BLK    = 6,
    parameter int          STRIDE = 3,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          CNT_W  = 16
) (
    input  logic                 ck,
    input  logic                 rst,
    bus_stim_gen_if.master       bus
);

    typedef enum logic [1:0] {
        MODE_ADDR   = 2'b00,
        MODE_DATA   = 2'b01,
        MODE_STRIDE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Popcount of a W-bit vector needs enough bits to hold W itself.
    localparam int PC_W  = $clog2(W + 1);
    // One extra bit above the wider of counter and popcount so overflow is visible in the sum.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [W-1:0]     a_q;
    logic [W-1:0]     a_nxt;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_nxt;
    logic             valid_q;
    logic             jump_q;
    logic             jump_nxt;
    logic [CNT_W-1:0] tog_q;
    logic [CNT_W-1:0] tog_nxt;

    logic [W-1:0]     diff;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    mode_t            mode_s;

    assign mode_s = mode_t'(bus.mode);

    // 16-bit Fibonacci LFSR, taps 16/14/13/11.
    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Next bus value; every mode works from the current A and the pre-advance LFSR.
    always_comb begin
        a_nxt    = a_q;
        jump_nxt = 1'b0;
        unique case (mode_s)
            MODE_ADDR: begin
                if (&a_q[BLK-1:0]) begin
                    // End of block: random block base, low field restarts at zero.
                    a_nxt    = {lfsr_q[W-1:BLK], {BLK{1'b0}}};
                    jump_nxt = 1'b1;
                end else begin
                    a_nxt = a_q + 1'b1;
                end
            end
            MODE_DATA:   a_nxt = lfsr_q[W-1:0];
            MODE_STRIDE: a_nxt = a_q + W'(STRIDE);
            MODE_HOLD:   a_nxt = a_q;
            default:     a_nxt = a_q;
        endcase
    end

    // Hamming distance between the current and next bus value.
    assign diff = a_q ^ a_nxt;

    always_comb begin
        pc = '0;
        for (int i = 0; i < W; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
    end

    // Saturate on the full-width sum so a wrap can never masquerade as a small count.
    always_comb begin
        sum = SUM_W'(tog_q) + SUM_W'(pc);
        if (|sum[SUM_W-1:CNT_W]) begin
            tog_nxt = {CNT_W{1'b1}};
        end else begin
            tog_nxt = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            tog_q   <= '0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                a_q    <= a_nxt;
                lfsr_q <= lfsr_nxt;
                jump_q <= jump_nxt;
            end else begin
                jump_q <= 1'b0;
            end
            // clr wins over accumulation; the update on the clearing edge is discarded.
            if (bus.clr) begin
                tog_q <= '0;
            end else if (bus.en) begin
                tog_q <= tog_nxt;
            end
        end
    end

    assign bus.A       = a_q;
    assign bus.valid   = valid_q;
    assign bus.jump    = jump_q;
    assign bus.tog_cnt = tog_q;

endmodule

// File: tb/tb_bus_stim_gen.sv
// Directed self-checking bench for bus_stim_gen: ADDR, DATA, STRIDE, en gap/HOLD, clr/saturation, async reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench steps en directly.
module tb_bus_stim_gen;

    logic ck;
    logic rst;

    int n_cmp;
    int n_err;

    bus_stim_gen_if #(.W(8), .CNT_W(16)) bus ();
    bus_stim_gen_if #(.W(8), .CNT_W(4))  sbus ();

    bus_stim_gen #(.W(8), .BLK(6), .STRIDE(3), .SEED(16'hACE1), .CNT_W(16)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.master)
    );

    bus_stim_gen #(.W(8), .BLK(6), .STRIDE(3), .SEED(16'hACE1), .CNT_W(4)) dut_sat (
        .ck  (ck),
        .rst (rst),
        .bus (sbus.master)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int popcnt(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.mode  = 2'b00;
        sbus.en   = 1'b0;
        sbus.clr  = 1'b0;
        sbus.mode = 2'b00;
        @(negedge ck);
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.A, bus.valid, bus.jump} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got A=%h valid=%b jump=%b want 00/0/0", bus.A, bus.valid, bus.jump);
        end
        n_cmp++;
        if (bus.tog_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_tog: got %0d want 0", bus.tog_cnt);
        end
        n_cmp++;
        if (dut.lfsr_q !== 16'hACE1) begin
            n_err++;
            $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_q);
        end
    endtask

    task automatic test_addr_run();
        logic [15:0] ml;
        logic [15:0] lj;
        logic [7:0]  base;
        logic [7:0]  ea;
        int          mt;
        do_reset();
        ml = 16'hACE1;
        bus.mode = 2'b00;
        bus.en   = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            tick();
            ml = lfsr_step(ml);
            ea = 8'(i);
            n_cmp++;
            if ({bus.A, bus.jump, bus.valid} !== {ea, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL addr_count edge %0d: got A=%h jump=%b valid=%b want %h/0/1", i, bus.A, bus.jump, bus.valid, ea);
            end
        end
        n_cmp++;
        if (bus.tog_cnt !== 16'd120) begin
            n_err++;
            $display("FAIL addr_tog63: got %0d want 120", bus.tog_cnt);
        end
        // first block jump
        lj = ml;
        tick();
        ml = lfsr_step(ml);
        base = {lj[7:6], 6'b0};
        mt = 120 + popcnt(8'h3F ^ base);
        n_cmp++;
        if ({bus.A, bus.jump, bus.valid} !== {base, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL addr_jump1: got A=%h jump=%b valid=%b want %h/1/1", bus.A, bus.jump, bus.valid, base);
        end
        n_cmp++;
        if (bus.tog_cnt !== 16'(mt)) begin
            n_err++;
            $display("FAIL addr_jump1_tog: got %0d want %0d", bus.tog_cnt, mt);
        end
        // second block, jump must be a single-cycle pulse and recur at the next block end
        for (int k = 1; k <= 63; k++) begin
            tick();
            ml = lfsr_step(ml);
            ea = base + 8'(k);
            n_cmp++;
            if ({bus.A, bus.jump} !== {ea, 1'b0}) begin
                n_err++;
                $display("FAIL addr_block2 step %0d: got A=%h jump=%b want %h/0", k, bus.A, bus.jump, ea);
            end
        end
        // clr together with en and a block jump
        bus.clr = 1'b1;
        lj = ml;
        tick();
        ml = lfsr_step(ml);
        bus.clr = 1'b0;
        base = {lj[7:6], 6'b0};
        n_cmp++;
        if ({bus.A, bus.jump, bus.valid} !== {base, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL addr_jump2_clr: got A=%h jump=%b valid=%b want %h/1/1", bus.A, bus.jump, bus.valid, base);
        end
        n_cmp++;
        if (bus.tog_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL addr_jump2_clr_tog: got %0d want 0", bus.tog_cnt);
        end
        tick();
        n_cmp++;
        if ({bus.A, bus.jump, bus.tog_cnt} !== {base + 8'd1, 1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL addr_after_clr: got A=%h jump=%b tog=%0d want %h/0/1", bus.A, bus.jump, bus.tog_cnt, base + 8'd1);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_data_seq();
        do_reset();
        bus.mode = 2'b01;
        bus.en   = 1'b1;
        tick();
        n_cmp++;
        if ({bus.A, bus.tog_cnt} !== {8'hE1, 16'd4}) begin
            n_err++;
            $display("FAIL data_first: got A=%h tog=%0d want e1/4", bus.A, bus.tog_cnt);
        end
        n_cmp++;
        if (dut.lfsr_q !== 16'h59C3) begin
            n_err++;
            $display("FAIL data_lfsr1: got %h want 59c3", dut.lfsr_q);
        end
        tick();
        n_cmp++;
        if ({bus.A, bus.tog_cnt} !== {8'hC3, 16'd6}) begin
            n_err++;
            $display("FAIL data_second: got A=%h tog=%0d want c3/6", bus.A, bus.tog_cnt);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_stride_wrap();
        logic [7:0] pa;
        logic [7:0] na;
        int         mt;
        do_reset();
        bus.mode = 2'b10;
        bus.en   = 1'b1;
        pa = 8'h00;
        mt = 0;
        repeat (85) begin
            tick();
            na = pa + 8'd3;
            mt += popcnt(pa ^ na);
            pa = na;
        end
        n_cmp++;
        if ({bus.A, bus.tog_cnt} !== {8'hFF, 16'(mt)}) begin
            n_err++;
            $display("FAIL stride_85: got A=%h tog=%0d want ff/%0d", bus.A, bus.tog_cnt, mt);
        end
        tick();
        mt += 7;
        n_cmp++;
        if ({bus.A, bus.tog_cnt} !== {8'h02, 16'(mt)}) begin
            n_err++;
            $display("FAIL stride_wrap: got A=%h tog=%0d want 02/%0d", bus.A, bus.tog_cnt, mt);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_en_gap_hold();
        logic [15:0] ml;
        logic [7:0]  ea;
        do_reset();
        ml = 16'hACE1;
        bus.mode = 2'b01;
        bus.en   = 1'b1;
        repeat (2) begin
            tick();
            ml = lfsr_step(ml);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.A, bus.tog_cnt, bus.valid, bus.jump} !== {8'hC3, 16'd6, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL en_gap %0d: got A=%h tog=%0d valid=%b want c3/6/0", i, bus.A, bus.tog_cnt, bus.valid);
            end
        end
        bus.mode = 2'b11;
        bus.en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ml = lfsr_step(ml);
            n_cmp++;
            if ({bus.A, bus.tog_cnt, bus.valid} !== {8'hC3, 16'd6, 1'b1}) begin
                n_err++;
                $display("FAIL hold %0d: got A=%h tog=%0d valid=%b want c3/6/1", i, bus.A, bus.tog_cnt, bus.valid);
            end
        end
        bus.mode = 2'b01;
        ea = ml[7:0];
        tick();
        n_cmp++;
        if ({bus.A, bus.tog_cnt} !== {ea, 16'(6 + popcnt(8'hC3 ^ ea))}) begin
            n_err++;
            $display("FAIL data_resume: got A=%h tog=%0d want %h/%0d", bus.A, bus.tog_cnt, ea, 6 + popcnt(8'hC3 ^ ea));
        end
        bus.en = 1'b0;
    endtask

    task automatic test_clr_sat();
        logic [15:0] ml;
        logic [7:0]  pa;
        logic [7:0]  ea;
        int          mt;
        do_reset();
        ml = 16'hACE1;
        pa = 8'h00;
        mt = 0;
        sbus.mode = 2'b01;
        sbus.en   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ea = ml[7:0];
            tick();
            ml = lfsr_step(ml);
            mt += popcnt(pa ^ ea);
            if (mt > 15) mt = 15;
            pa = ea;
            n_cmp++;
            if ({sbus.A, sbus.tog_cnt} !== {ea, 4'(mt)}) begin
                n_err++;
                $display("FAIL sat_run edge %0d: got A=%h tog=%0d want %h/%0d", i, sbus.A, sbus.tog_cnt, ea, mt);
            end
        end
        n_cmp++;
        if (sbus.tog_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_final: got %0d want 15", sbus.tog_cnt);
        end
        sbus.clr = 1'b1;
        ea = ml[7:0];
        tick();
        ml = lfsr_step(ml);
        sbus.clr = 1'b0;
        n_cmp++;
        if ({sbus.A, sbus.tog_cnt, sbus.valid} !== {ea, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL sat_clr: got A=%h tog=%0d valid=%b want %h/0/1", sbus.A, sbus.tog_cnt, sbus.valid, ea);
        end
        pa = ea;
        ea = ml[7:0];
        tick();
        n_cmp++;
        if (sbus.tog_cnt !== 4'(popcnt(pa ^ ea))) begin
            n_err++;
            $display("FAIL sat_after_clr: got %0d want %0d", sbus.tog_cnt, popcnt(pa ^ ea));
        end
        sbus.en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.mode = 2'b00;
        bus.en   = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if ({bus.A, bus.tog_cnt} !== {8'd5, 16'd8}) begin
            n_err++;
            $display("FAIL arst_pre: got A=%h tog=%0d want 05/8", bus.A, bus.tog_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.A, bus.valid, bus.jump, bus.tog_cnt} !== 26'd0) begin
            n_err++;
            $display("FAIL arst_immediate: got A=%h valid=%b jump=%b tog=%0d want all 0", bus.A, bus.valid, bus.jump, bus.tog_cnt);
        end
        @(negedge ck);
        rst = 1'b0;
        bus.mode = 2'b01;
        tick();
        n_cmp++;
        if ({bus.A, bus.valid} !== {8'hE1, 1'b1}) begin
            n_err++;
            $display("FAIL arst_data_first: got A=%h valid=%b want e1/1", bus.A, bus.valid);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.mode  = 2'b00;
        sbus.en   = 1'b0;
        sbus.clr  = 1'b0;
        sbus.mode = 2'b00;
        test_reset();
        test_addr_run();
        test_data_seq();
        test_stride_wrap();
        test_en_gap_hold();
        test_clr_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
